snake_dir_queue: RTL and testbench
==================================

// Module: snake_dir_queue
// PURPOSE
// Input stage directly upstream of the snake game core. Turns debounced button levels into
// a queue of legal direction changes, consumed once per game tick. Gives the core one
// Dir/StepEn pair per tick and owns pause and game-over gating.
// A quick double-tap such as UP then LEFT inside one tick is therefore kept as two moves,
// not collapsed into the last press.
// PARAMETERS
// DEPTH     2          queue entries (power of two, 2..8)
// INIT_DIR  `DIR_RIGHT direction loaded on Reset
// PORTS
// Clock      in   1  system clock (debouncer clock domain)
// Reset      in   1  synchronous, active-high
// Tick       in   1  game tick, single Clock-cycle pulse
// BtnUp      in   1  debounced level
// BtnDown    in   1  debounced level
// BtnLeft    in   1  debounced level
// BtnRight   in   1  debounced level
// BtnCenter  in   1  debounced level, pause toggle
// GameOver   in   1  level from core; sticky-forces OVER
// Dir        out  2  direction the snake moves on the current step
// StepEn     out  1  one-cycle pulse: core advances the snake by one cell using Dir
// Paused     out  1  high in PAUSED
// Count      out  $clog2(DEPTH)+1  queue occupancy
// BEHAVIOUR
// - Direction encoding, from Constants.v: UP=0, DOWN=1, LEFT=2, RIGHT=3.
//   Opposite(d) = {d[1], ~d[0]}.
// - Reset values: Dir=INIT_DIR, StepEn=0, Paused=0, Count=0, state=RUN.
//   Edge registers load the current button levels, so a button held through Reset never fires.
// - Edge detect: press = Btn & ~BtnPrev, registered every cycle.
//   If several directions press in one cycle, one candidate is taken, priority UP>DOWN>LEFT>RIGHT.
//   Center is detected independently.
// - Reference direction Ref = newest queued entry if Count>0, else Dir.
//   Both are sampled before any pop in the same cycle.
// - A candidate is pushed only if ALL of these hold:
//   - state==RUN;
//   - cand!=Ref and cand!=Opposite(Ref);
//   - Count<DEPTH, or a pop occurs in the same cycle.
//   Any other candidate is silently dropped; no error flag.
// - Pop: Tick in RUN with Count>0 -> Dir<=oldest entry, Count decrements.
//   Push and pop in the same cycle leave Count unchanged.
// - StepEn: Tick in RUN -> StepEn=1 on the next cycle, whether or not a pop happened.
//   Latency is 1 cycle and Dir is valid in that same cycle. StepEn is never high in PAUSED/OVER.
// - State machine (one 2-bit register):
//   - RUN --center press--> PAUSED.
//   - PAUSED --center press--> RUN.
//   - any --GameOver==1--> OVER.
//   - OVER is left only by Reset.
//   - GameOver takes priority over a center press in the same cycle.
// - PAUSED: queue contents and Dir are retained; direction presses are dropped; Tick is ignored.
// - OVER: queue flushed (Count=0) on entry; Dir frozen; all presses and Ticks ignored.
// - A Tick and a center press in the same cycle: the Tick is evaluated in the pre-transition state.
//   RUN->PAUSED still issues that final StepEn.
// - Reset mid-queue: everything returns to reset values on the next edge; a pending StepEn is cancelled.
// - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
// STRUCTURE
// - Constants.v gains: the DIR_* encodings above, ST_RUN=0, ST_PAUSED=1, ST_OVER=2.
// - Sub-module dir_fifo (DEPTH x 2-bit circular FIFO):
//   - inputs: Push, Pop, Flush;
//   - outputs: Head (oldest), Tail (newest), Count.
// - The parent holds edge detect, accept logic, state machine and StepEn.
// TESTING
// 1. Reset with BtnUp held, release, Tick.
//    -> no push, Count=0; StepEn=1 one cycle after Tick; Dir=3 (RIGHT).
// 2. From Dir=RIGHT: press UP, then LEFT, then Tick, then Tick.
//    -> Count 1 then 2; Dir=UP after first StepEn; Dir=LEFT after second StepEn; Count=0.
// 3. From Dir=RIGHT with an empty queue: press LEFT, then press RIGHT.
//    -> both dropped, Count stays 0.
//    Then press DOWN twice. -> exactly one entry queued.
// 4. DEPTH=2: queue UP, LEFT; press DOWN with no Tick.
//    -> dropped, Count=2.
//    Press DOWN in the same cycle as a Tick.
//    -> Count stays 2, Dir=UP, queue holds LEFT, DOWN.
// 5. Center press, then Ticks and an UP press.
//    -> Paused=1, no StepEn, no push.
//    Center again. -> Paused=0; the next Tick pops previously queued entries.
// 6. GameOver=1 while Count=1 and paused; then Ticks and button presses.
//    -> Paused=0, Count=0, StepEn held 0, Dir frozen.
//    Reset -> all reset values restored.

Source files
------------

// File: rtl/snake_dir_queue_pkg.sv
// Shared definitions for the snake direction queue.
//   - DIR_* : 2-bit direction codes used on Dir and inside the queue
//   - state_t : gating state of the input stage (RUN / PAUSED / OVER)
//   - opposite() : the direction that would reverse the snake onto itself
package snake_dir_queue_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_dir_queue_if.sv
// Bundle between the button/core side and the direction queue.
//   master : drives Tick, Btn*, GameOver; observes Dir, StepEn, Paused, Count, DbgState
//   slave  : the queue itself (opposite directions)
// Handshake: StepEn is a valid-only strobe. When StepEn is high for one cycle,
// Dir in that same cycle is the direction to step; the core has no ready and
// must consume it, so there is no back-pressure on this path.
interface snake_dir_queue_if
    import snake_dir_queue_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Tick;
    logic          BtnUp;
    logic          BtnDown;
    logic          BtnLeft;
    logic          BtnRight;
    logic          BtnCenter;
    logic          GameOver;
    logic [1:0]    Dir;
    logic          StepEn;
    logic          Paused;
    logic [CW-1:0] Count;
    state_t        DbgState;

    modport master (
        output Tick, BtnUp, BtnDown, BtnLeft, BtnRight, BtnCenter, GameOver,
        input  Dir, StepEn, Paused, Count, DbgState
    );

    modport slave (
        input  Tick, BtnUp, BtnDown, BtnLeft, BtnRight, BtnCenter, GameOver,
        output Dir, StepEn, Paused, Count, DbgState
    );

endinterface

// File: rtl/snake_dir_queue_dir_fifo.sv
// DEPTH x 2-bit circular FIFO holding pending direction changes.
//   Clock, Reset : system clock, synchronous active-high reset
//   Push, WrData : append WrData as the newest entry
//   Pop          : drop the oldest entry (caller guarantees Count>0)
//   Flush        : empty the queue; overrides Push and Pop
//   Head         : oldest entry, Tail : newest entry, Count : occupancy
module snake_dir_queue_dir_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic                       Flush,
    input  logic [1:0]                 WrData,
    output logic [1:0]                 Head,
    output logic [1:0]                 Tail,
    output logic [$clog2(DEPTH):0]     Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are AW bits over a power-of-two depth, so they wrap for free.
            if (Push) begin
                mem_d[wr_ptr_q] = WrData;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (Pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({Push, Pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign Head  = mem_q[rd_ptr_q];
    assign Tail  = mem_q[wr_ptr_q - AW'(1)];
    assign Count = count_q;

endmodule

// File: rtl/snake_dir_queue.sv
// Input stage in front of the snake game core. Converts debounced button
// levels into a queue of legal direction changes, hands the core one
// Dir/StepEn pair per game tick, and owns pause and game-over gating.
//   Clock, Reset : system clock, synchronous active-high reset
//   bus (slave)  : Tick, Btn{Up,Down,Left,Right,Center}, GameOver in;
//                  Dir, StepEn, Paused, Count, DbgState out
module snake_dir_queue
    import snake_dir_queue_pkg::*;
#(
    parameter int         DEPTH    = 2,
    parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
    input  logic               Clock,
    input  logic               Reset,
    snake_dir_queue_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Button vector: bit index of [3:0] equals the direction code.
    logic [4:0]    btn;
    logic [4:0]    btn_prev_q, btn_prev_d;
    logic [4:0]    press;

    state_t        state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic          step_en_q, step_en_d;

    logic [1:0]    cand;
    logic          cand_valid;
    logic [1:0]    ref_dir;
    logic          run_ok;
    logic          do_pop;
    logic          do_push;
    logic          do_flush;

    logic [1:0]    fifo_head;
    logic [1:0]    fifo_tail;
    logic [CW-1:0] fifo_count;

    assign btn   = {bus.BtnCenter, bus.BtnRight, bus.BtnLeft, bus.BtnDown, bus.BtnUp};
    assign press = btn & ~btn_prev_q;

    // Several simultaneous presses: lowest direction code wins (UP>DOWN>LEFT>RIGHT).
    always_comb begin
        cand       = DIR_UP;
        cand_valid = 1'b1;
        if (press[0])      cand = DIR_UP;
        else if (press[1]) cand = DIR_DOWN;
        else if (press[2]) cand = DIR_LEFT;
        else if (press[3]) cand = DIR_RIGHT;
        else               cand_valid = 1'b0;
    end

    // A new move is judged against where the snake will be heading once all
    // queued moves have been applied, not against the current direction.
    assign ref_dir = (fifo_count != '0) ? fifo_tail : dir_q;

    // GameOver wins over everything in its own cycle: no pop, push or step.
    assign run_ok   = (state_q == ST_RUN) && !bus.GameOver;
    assign do_pop   = run_ok && bus.Tick && (fifo_count != '0);
    assign do_push  = run_ok && cand_valid
                      && (cand != ref_dir) && (cand != opposite(ref_dir))
                      && ((fifo_count < CW'(DEPTH)) || do_pop);
    assign do_flush = bus.GameOver || (state_q == ST_OVER);

    snake_dir_queue_dir_fifo #(
        .DEPTH (DEPTH)
    ) u_dir_fifo (
        .Clock  (Clock),
        .Reset  (Reset),
        .Push   (do_push),
        .Pop    (do_pop),
        .Flush  (do_flush),
        .WrData (cand),
        .Head   (fifo_head),
        .Tail   (fifo_tail),
        .Count  (fifo_count)
    );

    // Datapath next-state: edge registers, Dir, StepEn.
    always_comb begin
        btn_prev_d = btn;
        dir_d      = do_pop ? fifo_head : dir_q;
        // Tick is judged in the current state, so a Tick coinciding with a
        // pausing center press still produces its step.
        step_en_d  = run_ok && bus.Tick;
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        if (bus.GameOver) begin
            state_d = ST_OVER;
        end else begin
            case (state_q)
                ST_RUN:    if (press[4]) state_d = ST_PAUSED;
                ST_PAUSED: if (press[4]) state_d = ST_RUN;
                ST_OVER:   state_d = ST_OVER;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // FSM + datapath registers. Edge registers load live levels on reset so a
    // button held through reset does not register as a press.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_RUN;
            dir_q      <= INIT_DIR;
            step_en_q  <= 1'b0;
            btn_prev_q <= btn;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            step_en_q  <= step_en_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    // FSM: outputs.
    always_comb begin
        bus.Paused   = (state_q == ST_PAUSED);
        bus.DbgState = state_q;
        bus.StepEn   = step_en_q;
        bus.Dir      = dir_q;
        bus.Count    = fifo_count;
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
module tb_snake_dir_queue;
    import snake_dir_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int W     = 4 + CW;   // {step, dir[1:0], count, paused}

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snake_dir_queue_if #(.DEPTH(DEPTH)) bus ();

    snake_dir_queue #(
        .DEPTH    (DEPTH),
        .INIT_DIR (DIR_RIGHT)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] status_q[$];   // expected per-cycle observable state
    logic [1:0]   exp_q[$];      // expected Dir on each StepEn
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Queue of pending directions plus current direction and mode
    // (0=running, 1=paused, 2=over).
    int         mq[$];
    logic [1:0] mdir;
    int         mmode;
    logic [4:0] mprev;
    logic       mstep;

    task automatic model_step(input logic r, input logic t, input logic [4:0] b, input logic g);
        logic [4:0] pr;
        int  cand;
        int  rdir;
        bit  live, pop, push;
        if (r) begin
            mdir  = 2'd3;
            mq.delete();
            mmode = 0;
            mstep = 1'b0;
            mprev = b;
            return;
        end
        pr    = b & ~mprev;
        mprev = b;
        cand  = -1;
        for (int i = 3; i >= 0; i--) if (pr[i]) cand = i;
        rdir  = (mq.size() > 0) ? mq[mq.size()-1] : int'(mdir);
        live  = (mmode == 0) && !g;
        pop   = live && t && (mq.size() > 0);
        push  = live && (cand >= 0) && (cand != rdir) && (cand != (rdir ^ 1))
                && ((mq.size() < DEPTH) || pop);
        mstep = live && t;
        if (pop)  mdir = 2'(mq.pop_front());
        if (push) mq.push_back(cand);
        if (g) begin
            mq.delete();
            mmode = 2;
        end else if (pr[4]) begin
            if (mmode == 0)      mmode = 1;
            else if (mmode == 1) mmode = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic t, input logic [4:0] b, input logic g);
        rst           = r;
        bus.Tick      = t;
        bus.BtnUp     = b[0];
        bus.BtnDown   = b[1];
        bus.BtnLeft   = b[2];
        bus.BtnRight  = b[3];
        bus.BtnCenter = b[4];
        bus.GameOver  = g;
        model_step(r, t, b, g);
        status_q.push_back({mstep, mdir, CW'(mq.size()), (mmode == 1)});
        if (mstep) exp_q.push_back(mdir);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'b0, 1'b0);
    endtask

    task automatic press(input logic [4:0] b, input logic t);
        cycle(1'b0, t, b, 1'b0);
        cycle(1'b0, 1'b0, 5'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        logic [1:0]   ed;
        forever begin
            @(posedge clk);
            #1;
            if (bus.StepEn === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("step_unexpected", 32'(bus.StepEn), 32'd0);
                end else begin
                    ed = exp_q.pop_front();
                    check("step_dir", 32'(bus.Dir), 32'(ed));
                end
            end
            if (status_q.size() > 0) begin
                e = status_q.pop_front();
                check("status{step,dir,count,paused}",
                      32'({bus.StepEn, bus.Dir, bus.Count, bus.Paused}), 32'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] b;
        logic       t, g, r;

        // 1: reset with UP held, release, Tick.
        cycle(1'b1, 1'b0, 5'b00001, 1'b0);
        cycle(1'b1, 1'b0, 5'b00001, 1'b0);
        cycle(1'b0, 1'b0, 5'b00001, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1, 5'b0, 1'b0);
        idle(2);

        // 2: UP, LEFT, Tick, Tick.
        press(5'b00001, 1'b0);
        press(5'b00100, 1'b0);
        press(5'b00000, 1'b1);
        press(5'b00000, 1'b1);
        idle(1);

        // 3: from LEFT after test 2 reset to RIGHT first; LEFT, RIGHT dropped; DOWN twice.
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        press(5'b00100, 1'b0);
        press(5'b01000, 1'b0);
        press(5'b00010, 1'b0);
        press(5'b00010, 1'b0);
        press(5'b00000, 1'b1);
        idle(1);

        // 4: full queue, DOWN dropped, then DOWN with a Tick.
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        press(5'b00001, 1'b0);
        press(5'b00100, 1'b0);
        press(5'b00010, 1'b0);
        press(5'b00010, 1'b1);
        press(5'b00000, 1'b1);
        press(5'b00000, 1'b1);
        idle(1);

        // 5: pause, Ticks and UP ignored, resume, Tick pops; Tick with center press.
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        press(5'b00001, 1'b0);
        press(5'b10000, 1'b0);
        press(5'b00000, 1'b1);
        press(5'b00100, 1'b0);
        press(5'b00000, 1'b1);
        press(5'b10000, 1'b0);
        press(5'b00000, 1'b1);
        press(5'b10000, 1'b1);
        press(5'b10000, 1'b0);

        // 6: GameOver while paused with one entry queued.
        press(5'b00100, 1'b0);
        press(5'b10000, 1'b0);
        cycle(1'b0, 1'b0, 5'b0, 1'b1);
        cycle(1'b0, 1'b1, 5'b00010, 1'b1);
        cycle(1'b0, 1'b1, 5'b10000, 1'b0);
        cycle(1'b0, 1'b1, 5'b00001, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, 5'b0, 1'b0);
        idle(2);

        // Random phase.
        b = 5'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                b[3:0] = 4'($urandom_range(0, 15));
                b[4]   = ($urandom_range(0, 7) == 0);
            end
            t = ($urandom_range(0, 3) == 0);
            g = ($urandom_range(0, 199) == 0);
            r = ($urandom_range(0, 299) == 0);
            cycle(r, t, b, g);
        end
        idle(3);

        check("drain_status_q", 32'(status_q.size()), 32'd0);
        check("drain_exp_q", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
